// File: rtl/fixed_to_float.sv
// Signed fixed-point (32-bit, programmable fraction width) to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest-even in a single ROUND cycle.
module fixed_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fixed,
  input  logic [4:0]  fixpointpos,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  fpp_q, fpp_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] result_q, result_d;

  logic        round_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_base;
  logic [7:0]  exp_rnd;

  // mag_q[31] is the hidden bit once normalised; bits below mag_q[8] feed rounding.
  assign round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign frac_sum = {1'b0, mag_q[30:8]} + {23'b0, round_up};
  assign exp_base = 8'd158 - {2'b00, n_q} - {3'b000, fpp_q};
  assign exp_rnd  = exp_base + {7'b0, frac_sum[23]};

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    fpp_d    = fpp_q;
    n_d      = n_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (fixed == 32'd0) begin
            result_d = 32'd0;
            state_d  = StDone;
          end else begin
            sign_d  = fixed[31];
            mag_d   = fixed[31] ? (~fixed + 32'd1) : fixed;
            fpp_d   = fixpointpos;
            n_d     = 6'd0;
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mag_q[31]) begin
          state_d = StRound;
        end else begin
          mag_d = mag_q << 1;
          n_d   = n_q + 6'd1;
        end
      end
      StRound: begin
        // On carry-out frac_sum[22:0] is already zero.
        result_d = {sign_q, exp_rnd, frac_sum[22:0]};
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      fpp_q    <= 5'd0;
      n_q      <= 6'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      fpp_q    <= fpp_d;
      n_q      <= n_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: doc/fixed_to_float.md
FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset; rst=0 forces reset state immediately regardless of clk.
REQ-003 SHALL have port start, input, 1, request to convert; sampled only in IDLE.
REQ-004 SHALL have port fixed, input, 32, two's-complement signed fixed-point operand.
REQ-005 SHALL have port fixpointpos, input, 5, number of fraction bits in fixed (value = fixed / 2^fixpointpos).
REQ-006 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-007 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-008 SHALL have port result, output, 32, IEEE-754 single-precision result, registered.

Function
REQ-009 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-010 In IDLE with start=1 at edge k: latch sign=fixed[31], mag=|fixed| as 32-bit unsigned (0x80000000 gives mag 0x80000000), latch fixpointpos, clear shift count n; go NORM.
REQ-011 In IDLE with start=1 and fixed=0: load result=0x00000000 and go directly to DONE (done high in cycle after edge k).
REQ-012 In NORM each cycle: if mag[31]=1 go ROUND; else mag<=mag<<1, n<=n+1, stay NORM.
REQ-013 n SHALL be 6 bits and never exceed 31.
REQ-014 In ROUND: biased exponent = 158 - n - fixpointpos (range 96..158, always normal, no denormal/overflow path); fraction = mag[30:8].
REQ-015 Rounding SHALL be round-to-nearest-even: guard=mag[7], sticky=OR(mag[6:0]), lsb=mag[8]; increment fraction iff guard & (sticky | lsb).
REQ-016 If increment carries out of the 23-bit fraction, fraction SHALL become 0 and exponent SHALL increase by 1.
REQ-017 ROUND SHALL register result={sign, exponent[7:0], fraction} and go DONE.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 Latency: nonzero operand with n leading-zero shifts gives done high in cycle after edge k+n+2; zero operand, cycle after edge k.
REQ-020 start while busy=1 SHALL be ignored; fixed and fixpointpos changes after edge k SHALL not affect the conversion.
REQ-021 result SHALL hold its last value until the next ROUND or zero-load; it SHALL not change during NORM.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new conversion is accepted only from IDLE (back-to-back accepted the cycle after done).
REQ-023 Negative zero SHALL never be produced.

Reset
REQ-024 On rst=0: state=IDLE, busy=0, done=0, result=0x00000000, n=0, mag=0, sign=0.
REQ-025 rst=0 during NORM or ROUND SHALL abort the conversion with no done pulse; after rst=1 the block accepts start in the first IDLE cycle.

Verification
REQ-026 fixed=0x00000100, fixpointpos=8, start pulse -> n=23, done in cycle after edge k+25, result=0x3F800000 (1.0).
REQ-027 fixed=0xFFFFFF00, fixpointpos=8 -> result=0xBF800000 (-1.0); fixed=0x80000000, fixpointpos=0 -> n=0, done after edge k+2, result=0xCF000000.
REQ-028 fixed=0x00000000, any fixpointpos -> done in cycle after edge k, result=0x00000000, busy high for one cycle only.
REQ-029 Rounding: fixed=0x7FFFFFFF, fixpointpos=0 -> mantissa carry, result=0x4F000000; fixed=0x01000001, fixpointpos=0 -> tie to even, result=0x4B800000.
REQ-030 Assert start again mid-NORM with different fixed -> ignored, first result unchanged; then assert rst=0 mid-NORM of a new conversion -> busy=0, done=0, result=0 immediately, no done pulse follows.
REQ-031 Bench SHALL compare every result against a reference model over random fixed/fixpointpos and check done is one cycle wide and busy=1 exactly from edge k until DONE exits.
